// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array scheduler.
package sa_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_KW        = 8;
  localparam int DEF_DRAIN_LAT = 3;

  // Cycles after the last operand leaves the buffer until PE[N-1][N-1] settles.
  function automatic int drain_len(input int n, input int lat);
    return 2 * (n - 1) + 1 + lat;
  endfunction

endpackage

// File: rtl/sa_sched_if.sv
// Job handshake, operand-buffer and array-control bundle for sa_sched.
interface sa_sched_if #(
  parameter int N  = 4,
  parameter int KW = 8
);
  logic              start;
  logic [KW-1:0]     k_len;
  logic              abort;
  logic              ready;
  logic              rd_en;
  logic [KW-1:0]     rd_addr;
  logic [N-1:0]      row_valid;
  logic [N-1:0]      col_valid;
  logic              pe_clear;
  logic [N*N-1:0]    pe_overflow;
  logic              res_valid;
  logic              ovf;
  logic              cmd_err;

  modport master (
    output start, k_len, abort, pe_overflow,
    input  ready, rd_en, rd_addr, row_valid, col_valid, pe_clear,
           res_valid, ovf, cmd_err
  );

  modport slave (
    input  start, k_len, abort, pe_overflow,
    output ready, rd_en, rd_addr, row_valid, col_valid, pe_clear,
           res_valid, ovf, cmd_err
  );
endinterface

// File: rtl/sa_skew_line.sv
// 1-bit delay line of DEPTH stages; flush empties every stage in one edge.
module sa_skew_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset || flush) sr <= '0;
    else                sr <= (sr << 1) | DEPTH'(d);
  end

  assign q = sr[DEPTH-1];
endmodule

// File: rtl/sa_sched.sv
// Systolic-array job scheduler: clear, feed k_len operand pairs, drain, report.
// Optional feature: define SA_SCHED_OVF_STICKY_EN to accumulate pe_overflow into ovf.
module sa_sched
  import sa_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int KW        = DEF_KW,
  parameter int DRAIN_LAT = DEF_DRAIN_LAT
) (
  input logic        clk,
  input logic        reset,
  sa_sched_if.slave  bus
);
  localparam int DLEN = drain_len(N, DRAIN_LAT);
  localparam int DW   = $clog2(DLEN + 1);

  state_t        state;
  logic [KW-1:0] k_reg;
  logic [DW-1:0] dcnt;
  logic          busy, kill, accept, ovf_any;
  logic [N-1:0]  row_v, col_v;

  assign busy   = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
  assign kill   = busy && bus.abort;
  assign accept = (state == S_IDLE) && bus.start && (bus.k_len != '0);

`ifdef SA_SCHED_OVF_STICKY_EN
  logic sticky;
  assign ovf_any = sticky | (|bus.pe_overflow);

  always_ff @(posedge clk) begin
    if (reset)       sticky <= 1'b0;
    else if (accept) sticky <= 1'b0;
    else if (busy)   sticky <= ovf_any;
  end
`else
  assign ovf_any = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      k_reg         <= '0;
      dcnt          <= '0;
      bus.ready     <= 1'b1;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.pe_clear  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.cmd_err   <= 1'b0;
    end else begin
      bus.pe_clear  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.cmd_err   <= 1'b0;
      if (kill) begin
        // Abandon the job; scrub any partial sums left in the array.
        state        <= S_IDLE;
        bus.ready    <= 1'b1;
        bus.rd_en    <= 1'b0;
        bus.rd_addr  <= '0;
        bus.pe_clear <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              state        <= S_CLEAR;
              k_reg        <= bus.k_len;
              bus.ready    <= 1'b0;
              bus.pe_clear <= 1'b1;
            end else if (bus.start) begin
              bus.cmd_err  <= 1'b1;
            end
          end
          S_CLEAR: begin
            state       <= S_FEED;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= '0;
          end
          S_FEED: begin
            if (bus.rd_addr == k_reg - KW'(1)) begin
              state       <= S_DRAIN;
              bus.rd_en   <= 1'b0;
              bus.rd_addr <= '0;
              dcnt        <= DW'(DLEN - 1);
            end else begin
              bus.rd_addr <= bus.rd_addr + KW'(1);
            end
          end
          S_DRAIN: begin
            if (dcnt == '0) begin
              state         <= S_DONE;
              bus.res_valid <= 1'b1;
              bus.ovf       <= ovf_any;
            end else begin
              dcnt <= dcnt - DW'(1);
            end
          end
          S_DONE: begin
            state     <= S_IDLE;
            bus.ready <= 1'b1;
          end
          default: begin
            state     <= S_IDLE;
            bus.ready <= 1'b1;
            bus.rd_en <= 1'b0;
          end
        endcase
      end
    end
  end

  // Row/column i sees the read strobe after buffer latency plus i hops of skew.
  for (genvar i = 0; i < N; i++) begin : g_skew
    sa_skew_line #(.DEPTH(i + 1)) u_row (
      .clk(clk), .reset(reset), .flush(kill), .d(bus.rd_en), .q(row_v[i])
    );
    sa_skew_line #(.DEPTH(i + 1)) u_col (
      .clk(clk), .reset(reset), .flush(kill), .d(bus.rd_en), .q(col_v[i])
    );
  end

  assign bus.row_valid = row_v;
  assign bus.col_valid = col_v;

endmodule

// File: tb/tb_sa_sched.sv
// Directed bench for sa_sched (N=4, KW=8, DRAIN_LAT=3); inputs change and
// outputs are sampled on the falling edge.
module tb_sa_sched;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

`ifdef SA_SCHED_OVF_STICKY_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  sa_sched_if #(.N(4), .KW(8)) bus ();

  sa_sched #(.N(4), .KW(8), .DRAIN_LAT(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Cycle 0 = start sampled. CLEAR at 1, FEED 2..k+1, DRAIN 10 cycles, DONE k+12.
  task automatic run_trace(input int k, input string tag);
    logic [12:0] obs, exp;
    logic [3:0]  rv;
    bus.start = 1'b1; bus.k_len = 8'(k);
    for (int c = 1; c <= k + 13; c++) begin
      @(negedge clk);
      bus.start = (c == 3);
      bus.k_len = (c == 3) ? 8'd0 : 8'(k);
      for (int i = 0; i < 4; i++) rv[i] = (c >= 3 + i) && (c <= k + 2 + i);
      exp = {c >= k + 13, c == 1, (c >= 2) && (c <= k + 1), c == k + 12, 1'b0, rv, rv};
      obs = {bus.ready, bus.pe_clear, bus.rd_en, bus.res_valid, bus.cmd_err,
             bus.row_valid, bus.col_valid};
      n_chk++;
      if (obs !== exp) $display("FAIL %s ctl cyc %0d: got %b want %b", tag, c, obs, exp);
      else n_pass++;
      if ((c >= 2) && (c <= k + 1)) begin
        n_chk++;
        if (bus.rd_addr !== 8'(c - 2))
          $display("FAIL %s rd_addr cyc %0d: got %0d want %0d", tag, c, bus.rd_addr, c - 2);
        else n_pass++;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    logic [24:0] obs;
    bus.start = 1'b0; bus.k_len = '0; bus.abort = 1'b0; bus.pe_overflow = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    obs = {bus.ready, bus.rd_en, bus.pe_clear, bus.res_valid, bus.ovf, bus.cmd_err,
           bus.rd_addr, bus.row_valid, bus.col_valid, 3'b000};
    n_chk++;
    if (obs !== {1'b1, 24'd0}) $display("FAIL reset state: got %b want %b", obs, {1'b1, 24'd0});
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.ready, bus.pe_clear} !== 2'b10)
      $display("FAIL reset release: ready/pe_clear %b want 10", {bus.ready, bus.pe_clear});
    else n_pass++;
  endtask

  task automatic test_kzero;
    bus.start = 1'b1; bus.k_len = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    n_chk++;
    if ({bus.cmd_err, bus.ready, bus.pe_clear} !== 3'b110)
      $display("FAIL kzero pulse: err/ready/clr %b want 110", {bus.cmd_err, bus.ready, bus.pe_clear});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({bus.cmd_err, bus.ready, bus.pe_clear} !== 3'b010)
      $display("FAIL kzero after: err/ready/clr %b want 010", {bus.cmd_err, bus.ready, bus.pe_clear});
    else n_pass++;
  endtask

  task automatic test_abort;
    int seen = 0;
    bus.start = 1'b1; bus.k_len = 8'd5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    n_chk++;
    if ({bus.rd_en, bus.rd_addr} !== {1'b1, 8'd2})
      $display("FAIL abort setup: rd_en/addr %b/%0d want 1/2", bus.rd_en, bus.rd_addr);
    else n_pass++;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_chk++;
    if ({bus.rd_en, bus.pe_clear, bus.ready, bus.row_valid, bus.col_valid} !== 11'b01100000000)
      $display("FAIL abort next: en/clr/rdy/row/col %b want 01100000000",
               {bus.rd_en, bus.pe_clear, bus.ready, bus.row_valid, bus.col_valid});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({bus.pe_clear, bus.ready} !== 2'b01)
      $display("FAIL abort idle: clr/rdy %b want 01", {bus.pe_clear, bus.ready});
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL abort res_valid: got %0d pulses want 0", seen);
    else n_pass++;
  endtask

  task automatic test_abort_start;
    bus.start = 1'b1; bus.k_len = 8'd3; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_chk++;
    if ({bus.pe_clear, bus.ready} !== 2'b10)
      $display("FAIL start-vs-abort: clr/rdy %b want 10", {bus.pe_clear, bus.ready});
    else n_pass++;
    // Abort still high: now lands in CLEAR.
    @(negedge clk);
    bus.abort = 1'b0;
    n_chk++;
    if ({bus.ready, bus.pe_clear, bus.rd_en} !== 3'b110)
      $display("FAIL abort in clear: rdy/clr/en %b want 110", {bus.ready, bus.pe_clear, bus.rd_en});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_drain;
    int seen = 0;
    bus.start = 1'b1; bus.k_len = 8'd2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if ({bus.ready, bus.rd_en, bus.pe_clear, bus.res_valid, bus.ovf, bus.cmd_err,
         bus.rd_addr, bus.row_valid, bus.col_valid} !== {1'b1, 21'd0})
      $display("FAIL reset in drain: got %b", {bus.ready, bus.rd_en, bus.pe_clear,
               bus.res_valid, bus.ovf, bus.cmd_err, bus.rd_addr, bus.row_valid, bus.col_valid});
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.res_valid || !bus.ready) seen++;
    end
    n_chk++;
    if (seen !== 0) $display("FAIL post-reset idle: got %0d bad cycles want 0", seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    bus.start = 1'b1; bus.k_len = 8'd3;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 15) begin
        n_chk++;
        if (bus.res_valid !== 1'b1) $display("FAIL b2b done: res_valid %b want 1", bus.res_valid);
        else n_pass++;
      end
      if (c == 16) begin
        n_chk++;
        if ({bus.ready, bus.cmd_err} !== 2'b10)
          $display("FAIL b2b idle: rdy/err %b want 10", {bus.ready, bus.cmd_err});
        else n_pass++;
      end
      if (c == 17) begin
        n_chk++;
        if ({bus.pe_clear, bus.ready} !== 2'b10)
          $display("FAIL b2b accept: clr/rdy %b want 10", {bus.pe_clear, bus.ready});
        else n_pass++;
      end
      if (c == 18 || c == 19) begin
        n_chk++;
        if ({bus.rd_en, bus.rd_addr} !== {1'b1, 8'(c - 18)})
          $display("FAIL b2b restart cyc %0d: en/addr %b/%0d want 1/%0d", c, bus.rd_en, bus.rd_addr, c - 18);
        else n_pass++;
      end
    end
    bus.start = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ovf;
    bus.start = 1'b1; bus.k_len = 8'd2;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.pe_overflow = (c == 6) ? 16'h0020 : 16'h0000;
    end
    n_chk++;
    if ({bus.res_valid, bus.ovf} !== {1'b1, EXP_OVF})
      $display("FAIL ovf job1: valid/ovf %b want %b", {bus.res_valid, bus.ovf}, {1'b1, EXP_OVF});
    else n_pass++;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    n_chk++;
    if ({bus.res_valid, bus.ovf} !== 2'b10)
      $display("FAIL ovf job2: valid/ovf %b want 10", {bus.res_valid, bus.ovf});
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    run_trace(5, "basic");
    run_trace(1, "kmin");
    test_kzero;
    test_abort;
    test_abort_start;
    test_reset_drain;
    test_back_to_back;
    test_ovf;
    run_trace(255, "kmax");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
